// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the frame sequencer slice.
// Provides the FSM state encoding, plot operation codes and a width helper
// used to size the object-select bus.
package frame_seq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 4'd0,
        S_ARM   = 4'd1,
        S_CLEAR = 4'd2,
        S_LOAD  = 4'd3,
        S_DRAW  = 4'd4,
        S_CHECK = 4'd5,
        S_WAIT  = 4'd6,
        S_ERASE = 4'd7,
        S_OVER  = 4'd8
    } state_t;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;

    // A single object still needs a one-bit select so the port never collapses to zero width.
    function automatic int obj_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control bundle between the frame sequencer and the coordinate/plot datapath.
// master: the sequencer (drives datapath controls, receives key/collision inputs).
// slave:  the datapath/input side.
interface frame_sequencer_if #(
    parameter int NUM_OBJ = 2
);
    import frame_seq_pkg::*;

    localparam int OBJ_W = obj_width(NUM_OBJ);

    logic             start;
    logic             touch_edge;
    logic             pause;
    logic             move_en;
    logic             load_coord;
    logic             datapath_en;
    logic             plot;
    logic [1:0]       op;
    logic [OBJ_W-1:0] obj_sel;
    logic             reset_n_out;
    logic             game_over;

    modport master (
        input  start, touch_edge, pause,
        output move_en, load_coord, datapath_en, plot, op, obj_sel, reset_n_out, game_over
    );

    modport slave (
        output start, touch_edge, pause,
        input  move_en, load_coord, datapath_en, plot, op, obj_sel, reset_n_out, game_over
    );

endinterface

// File: rtl/frame_sequencer_term_counter.sv
// Terminal counter: counts 0..MAX-1 while enabled and flags the final count.
// It wraps to zero on the terminal count so back-to-back runs need no extra clear cycle.
module term_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] cnt;

    assign last = (cnt == W'(MAX - 1));

    // Count register: clear has priority over enable, wrap on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Game-frame controller: start handshake, board clear, per-object load/draw,
// collision check, frame wait and per-object erase for NUM_OBJ sprites.
// Optional feature macro: FRAME_SEQ_PAUSE_EN -- when defined, pause freezes the
// frame wait and holds move_en low; when undefined, pause is ignored.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int NUM_OBJ       = 2,
    parameter int SPRITE_PIXELS = 250,
    parameter int FRAME_TICKS   = 1666666
) (
    input  logic                  clk,
    input  logic                  reset_n,
    frame_sequencer_if.master     bus
);

    localparam int OBJ_W = obj_width(NUM_OBJ);

    state_t           state;
    state_t           state_next;
    logic [OBJ_W-1:0] obj_idx;
    logic [OBJ_W-1:0] obj_idx_next;

    logic pix_en;
    logic pix_clr;
    logic pix_last;
    logic frm_en;
    logic frm_clr;
    logic frm_last;
    logic frm_hold;
    logic obj_last;

`ifdef FRAME_SEQ_PAUSE_EN
    assign frm_hold = bus.pause;
`else
    assign frm_hold = 1'b0;
    logic unused_pause;
    assign unused_pause = bus.pause;
`endif

    // The pixel counter only runs during plotting; outside it is held clear so every
    // sprite starts at pixel 0, and the wrap on the last pixel covers object-to-object runs.
    assign pix_en  = (state == S_DRAW) || (state == S_ERASE);
    assign pix_clr = !pix_en;

    // The frame counter only runs in WAIT and stalls while a pause is being honoured.
    assign frm_en  = (state == S_WAIT) && !frm_hold;
    assign frm_clr = (state != S_WAIT);

    assign obj_last = (obj_idx == OBJ_W'(NUM_OBJ - 1));
    assign bus.obj_sel = obj_idx;

    term_counter #(.MAX(SPRITE_PIXELS)) u_pix_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (pix_clr),
        .en    (pix_en),
        .last  (pix_last)
    );

    term_counter #(.MAX(FRAME_TICKS)) u_frm_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (frm_clr),
        .en    (frm_en),
        .last  (frm_last)
    );

    // State and object-index registers, cleared asynchronously so plotting stops at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            obj_idx <= '0;
        end else begin
            state   <= state_next;
            obj_idx <= obj_idx_next;
        end
    end

    // Next-state, next object index and Moore output decode.
    always_comb begin
        state_next      = state;
        obj_idx_next    = obj_idx;
        bus.move_en     = 1'b0;
        bus.load_coord  = 1'b0;
        bus.datapath_en = 1'b0;
        bus.plot        = 1'b0;
        bus.op          = OP_DRAW;
        bus.reset_n_out = 1'b1;
        bus.game_over   = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_ARM;
                end
            end

            S_ARM: begin
                if (!bus.start) begin
                    state_next = S_CLEAR;
                end
            end

            S_CLEAR: begin
                bus.reset_n_out = 1'b0;
                obj_idx_next    = '0;
                state_next      = S_LOAD;
            end

            S_LOAD: begin
                bus.load_coord = 1'b1;
                state_next     = S_DRAW;
            end

            S_DRAW: begin
                bus.move_en     = 1'b1;
                bus.datapath_en = 1'b1;
                bus.plot        = 1'b1;
                bus.op          = OP_DRAW;
                if (pix_last) begin
                    if (obj_last) begin
                        obj_idx_next = '0;
                        state_next   = S_CHECK;
                    end else begin
                        obj_idx_next = obj_idx + 1'b1;
                        state_next   = S_LOAD;
                    end
                end
            end

            S_CHECK: begin
                state_next = bus.touch_edge ? S_OVER : S_WAIT;
            end

            S_WAIT: begin
                bus.move_en = !frm_hold;
                if (frm_en && frm_last) begin
                    obj_idx_next = '0;
                    state_next   = S_ERASE;
                end
            end

            S_ERASE: begin
                bus.move_en     = 1'b1;
                bus.datapath_en = 1'b1;
                bus.plot        = 1'b1;
                bus.op          = OP_ERASE;
                if (pix_last) begin
                    if (obj_last) begin
                        obj_idx_next = '0;
                        state_next   = S_LOAD;
                    end else begin
                        obj_idx_next = obj_idx + 1'b1;
                        state_next   = S_ERASE;
                    end
                end
            end

            S_OVER: begin
                bus.game_over = 1'b1;
                if (bus.start) begin
                    state_next = S_ARM;
                end
            end

            default: begin
                state_next   = S_IDLE;
                obj_idx_next = '0;
            end
        endcase
    end

endmodule
